booth_mult_ctrl: RTL and testbench

Sequencer for the radix-2 Booth shift-add multiplier. It owns the combined accumulator/multiplier shift register and its iteration counter. It accepts a start request with two signed operands, steps one Booth iteration per clock (add/subtract/none, then arithmetic right shift), and presents a signed product with a one-cycle done pulse. It sits between the ALU issue logic and the multiplier datapath and is the only block that drives load and shift for that datapath.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_addsub.sv | 22 ++
 rtl/booth_mult_ctrl.sv | 123 ++++++++++++
 tb/tb_booth_mult_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: FSM states, op encoding, default width.
package booth_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_t;

  // Booth recoding of the {Q0, Q-1} pair.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational accumulator adder/subtractor for one Booth iteration.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int unsigned W = N_DEFAULT + 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  booth_op_t    op_i,
  output logic [W-1:0] res_c
);

  always_comb begin
    res_c = a_i;
    case (op_i)
      ADD:     res_c = a_i + b_i;
      SUB:     res_c = a_i - b_i;
      default: res_c = a_i;
    endcase
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth shift-add multiplier sequencer; owns the A:Q:Q-1 register and iteration count.
// Optional BOOTH_EARLY_TERM_EN: finish early once no further add/sub can occur.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned AW = N + 1;
  localparam int unsigned RW = 2 * N + 2;
  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [AW-1:0]   mx_q, mx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, done_q;

  logic [AW-1:0]   sum_c;
  logic [RW-1:0]   r_step_c;
  logic [CW-1:0]   cnt_nx_c;
  booth_op_t       op_c;

  assign op_c = booth_decode(r_q[1:0]);

  booth_addsub #(.W(AW)) u_addsub (
    .a_i   (r_q[RW-1:N+1]),
    .b_i   (mx_q),
    .op_i  (op_c),
    .res_c (sum_c)
  );

  // One iteration: add/sub into A, then arithmetic shift of the whole register.
  assign r_step_c = {sum_c[AW-1], sum_c, r_q[N:1]};
  assign cnt_nx_c = cnt_q - CW'(1);

`ifdef BOOTH_EARLY_TERM_EN
  logic            early_c;
  logic [RW-1:0]   r_skip_c;

  // After this step, if the remaining Q bits and Q-1 all match, the rest are pure shifts.
  always_comb begin
    early_c = 1'b1;
    for (int unsigned i = 1; i < N; i++) begin
      if ((CW'(i) <= cnt_nx_c) && (r_step_c[i] != r_step_c[0])) early_c = 1'b0;
    end
  end

  assign r_skip_c = RW'($signed(r_step_c) >>> cnt_nx_c);
`endif

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    mx_d      = mx_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          r_d     = {AW'(0), multiplier, 1'b0};
          mx_d    = {multiplicand[N-1], multiplicand};
          cnt_d   = CW'(N);
        end
      end
      RUN: begin
        r_d   = r_step_c;
        cnt_d = cnt_nx_c;
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = r_step_c[PW:1];
        end
`ifdef BOOTH_EARLY_TERM_EN
        if (early_c) begin
          state_d   = DONE;
          r_d       = r_skip_c;
          cnt_d     = '0;
          product_d = r_skip_c[PW:1];
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      mx_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      mx_q      <= mx_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed-vector bench for booth_mult_ctrl (N=4), plus abort, back-to-back and sweep sequences.
module tb_booth_mult_ctrl;

  localparam int unsigned N = 4;

  typedef struct {
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [2*N-1:0] p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   mcand = '0;
  logic [N-1:0]   mplier = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_chk = 0;
  int n_fail = 0;

  booth_mult_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic accept(input logic [N-1:0] m, input logic [N-1:0] q);
    start = 1'b1;
    mcand = m;
    mplier = q;
    @(posedge clk);
    #1;
    start = 1'b0;
    mcand = N'($urandom);
    mplier = N'($urandom);
  endtask

  // Edge count includes the accepting edge; bounded wait.
  task automatic wait_done(input int lat0, output int lat, output int busy_cyc);
    lat = lat0;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_vec(input logic [N-1:0] m, input logic [N-1:0] q,
                         input logic [2*N-1:0] exp, input string name);
    int lat, bc;
    accept(m, q);
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(1, lat, bc);
    check({name, "_product"}, 32'(product), 32'(exp));
    check({name, "_busy_at_done"}, 32'(busy), 32'd1);
`ifdef BOOTH_EARLY_TERM_EN
    check({name, "_lat_range"}, 32'(lat >= 2 && lat <= N + 1), 32'd1);
`else
    check({name, "_latency"}, 32'(lat), 32'(N + 1));
    check({name, "_busy_cycles"}, 32'(bc + 1), 32'(N + 1));
`endif
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
    check({name, "_product_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    vec_t vecs[8];
    int lat, bc;
    logic signed [N-1:0] ms, qs;
    int p;
    logic [2*N-1:0] pe;

    vecs[0] = '{4'h3, 4'h5, 8'h0F};
    vecs[1] = '{4'hD, 4'h5, 8'hF1};
    vecs[2] = '{4'h7, 4'h8, 8'hC8};
    vecs[3] = '{4'h8, 4'h8, 8'h40};
    vecs[4] = '{4'h0, 4'hF, 8'h00};
    vecs[5] = '{4'hF, 4'hF, 8'h01};
    vecs[6] = '{4'h7, 4'h7, 8'h31};
    vecs[7] = '{4'h8, 4'h7, 8'hC8};

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      run_vec(vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));

    // start during RUN is ignored; first result must survive
    accept(4'h3, 4'h5);
    @(posedge clk);
    #1;
    start = 1'b1;
    mcand = 4'h7;
    mplier = 4'h7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, lat, bc);
    check("ignore_product", 32'(product), 32'h0F);
    check("ignore_latency", 32'(lat), 32'(N + 1));

    // start raised in DONE: taken on the following IDLE edge
    start = 1'b1;
    mcand = 4'hD;
    mplier = 4'h5;
    @(posedge clk);
    #1;
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done(1, lat, bc);
    check("b2b_product", 32'(product), 32'hF1);
    check("b2b_latency", 32'(lat), 32'(N + 1));
    @(posedge clk);
    #1;

    // async reset mid-RUN, after e2
    accept(4'h7, 4'h8);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(4'h3, 4'h5, 8'h0F, "post_abort");

`ifdef BOOTH_EARLY_TERM_EN
    accept(4'h5, 4'h0);
    wait_done(1, lat, bc);
    check("early_q0_latency", 32'(lat), 32'd2);
    check("early_q0_product", 32'(product), 32'h00);
    @(posedge clk);
    #1;
    accept(4'h5, 4'h1);
    wait_done(1, lat, bc);
    check("early_q1_latency_le3", 32'(lat <= 3), 32'd1);
    check("early_q1_product", 32'(product), 32'h05);
    @(posedge clk);
    #1;
`endif

    // exhaustive operand sweep against a signed-multiply model
    for (int mi = 0; mi < 16; mi++) begin
      for (int qi = 0; qi < 16; qi++) begin
        ms = N'(mi);
        qs = N'(qi);
        p = int'(ms) * int'(qs);
        pe = p[2*N-1:0];
        accept(N'(mi), N'(qi));
        wait_done(1, lat, bc);
        check($sformatf("sweep_m%0h_q%0h", mi, qi), 32'(product), 32'(pe));
        @(posedge clk);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
